// File: rtl/ram_pkg.sv
// Shared definitions for the banked synchronous RAM.
// Holds the controller state type and the default geometry parameters.
package ram_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned BANKS_DEF  = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

endpackage : ram_pkg

// File: rtl/ram_bank.sv
// One bank of the banked RAM: single-port synchronous array with a registered read.
// Ports:
//   clk, rst_n  - clock, async active-low reset (read register only; array is not reset)
//   we_i        - write strobe, wdata_i stored at addr_i on the rising edge
//   re_i        - read strobe, read register loads mem[addr_i] on the rising edge
//   addr_i      - in-bank word offset
//   wdata_i     - write data
//   rdata_o     - read register, holds until the next read of this bank
module ram_bank #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array; contents are defined only by writes (including the clear sweep).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : ram_bank

// File: rtl/ram_banked_sync.sv
// Banked synchronous RAM with a hardware clear sweep.
// After reset (or a clr request) every word is zeroed, one in-bank offset per cycle
// across all banks at once; busy is high for that sweep. In READY, one access per
// cycle is accepted while _ce is low: writes land on the sampling edge, reads load
// the selected bank's read register one cycle later and pulse rd_valid.
// Ports:
//   clk, _rst  - clock, async active-low reset
//   adrs       - word address; top log2(BANKS) bits select the bank
//   dataIn     - write data
//   _ce, _we   - active-low access strobe, active-low write select
//   _oe        - active-low output enable (combinational on dataOut)
//   clr        - request to zero the whole array
//   dataOut    - read register of the last-read bank, or zero when _oe is high
//   rd_valid   - one-cycle pulse when new read data is available
//   busy       - high while the clear sweep runs
//   _cee       - registered active-low bank enables of the last accepted access
module ram_banked_sync
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BANKS  = BANKS_DEF
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic [ADDR_W-1:0] adrs,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              _ce,
    input  logic              _we,
    input  logic              _oe,
    input  logic              clr,
    output logic [DATA_W-1:0] dataOut,
    output logic              rd_valid,
    output logic              busy,
    output logic [BANKS-1:0]  _cee
);

    localparam int unsigned BSEL_W = $clog2(BANKS);
    localparam int unsigned OFF_W  = ADDR_W - BSEL_W;

    ram_state_e        state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              rd_valid_q, rd_valid_d;
    logic [BANKS-1:0]  cee_q, cee_d;
    logic [BSEL_W-1:0] bsel_q, bsel_d;

    logic [BSEL_W-1:0] bsel_c;
    logic [OFF_W-1:0]  off_c;
    logic [BANKS-1:0]  bank_we_c;
    logic [BANKS-1:0]  bank_re_c;
    logic [OFF_W-1:0]  bank_addr_c;
    logic [DATA_W-1:0] bank_wdata_c;
    logic [DATA_W-1:0] bank_rdata [BANKS];

    assign bsel_c = adrs[ADDR_W-1 -: BSEL_W];
    assign off_c  = adrs[OFF_W-1:0];

    // State and output registers.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            cee_q      <= '1;
            bsel_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            cee_q      <= cee_d;
            bsel_q     <= bsel_d;
        end
    end

    // Next-state and bank control.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        rd_valid_d   = 1'b0;
        cee_d        = '1;
        bsel_d       = bsel_q;
        bank_we_c    = '0;
        bank_re_c    = '0;
        bank_addr_c  = off_c;
        bank_wdata_c = dataIn;

        case (state_q)
            CLEAR: begin
                // Zero the current offset in every bank; user strobes are ignored.
                bank_we_c    = '1;
                bank_addr_c  = cnt_q;
                bank_wdata_c = '0;
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == '1) begin
                    cnt_d   = '0;
                    state_d = READY;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + OFF_W'(1);
                end
            end
            READY: begin
                if (!_ce) begin
                    cee_d = ~(BANKS'(1) << bsel_c);
                    if (!_we) begin
                        bank_we_c[bsel_c] = 1'b1;
                    end else begin
                        bank_re_c[bsel_c] = 1'b1;
                        rd_valid_d        = 1'b1;
                        bsel_d            = bsel_c;
                    end
                end
                // The access above still completes; the sweep starts on the next edge.
                if (clr) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                busy_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar b = 0; b < int'(BANKS); b++) begin : g_bank
        ram_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (OFF_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (_rst),
            .we_i    (bank_we_c[b]),
            .re_i    (bank_re_c[b]),
            .addr_i  (bank_addr_c),
            .wdata_i (bank_wdata_c),
            .rdata_o (bank_rdata[b])
        );
    end

    // Output mux follows the bank of the last read, so the value holds between reads.
    assign dataOut  = _oe ? '0 : bank_rdata[bsel_q];
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign _cee     = cee_q;

endmodule : ram_banked_sync

// File: tb/tb_ram_banked_sync.sv
module tb_ram_banked_sync;

    logic        clk = 1'b0;
    logic        rst_n;

    // Default-geometry instance (DATA_W=16, ADDR_W=7, BANKS=2)
    logic [6:0]  adrs;
    logic [15:0] din;
    logic        ce_n, we_n, oe_n, clr;
    logic [15:0] dout;
    logic        rdv, busy;
    logic [1:0]  cee;

    // Four-bank instance (ADDR_W=8, BANKS=4)
    logic [7:0]  f_adrs;
    logic [15:0] f_din;
    logic        f_ce_n, f_we_n, f_oe_n, f_clr;
    logic [15:0] f_dout;
    logic        f_rdv, f_busy;
    logic [3:0]  f_cee;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_banked_sync dut (
        .clk(clk), ._rst(rst_n), .adrs(adrs), .dataIn(din), ._ce(ce_n), ._we(we_n),
        ._oe(oe_n), .clr(clr), .dataOut(dout), .rd_valid(rdv), .busy(busy), ._cee(cee)
    );

    ram_banked_sync #(.DATA_W(16), .ADDR_W(8), .BANKS(4)) dut4 (
        .clk(clk), ._rst(rst_n), .adrs(f_adrs), .dataIn(f_din), ._ce(f_ce_n), ._we(f_we_n),
        ._oe(f_oe_n), .clr(f_clr), .dataOut(f_dout), .rd_valid(f_rdv), .busy(f_busy), ._cee(f_cee)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the default instance: a flat 128-word memory,
    // a busy flag with a sweep position, and the last-read word.
    logic [15:0] m_mem [128];
    bit          m_busy = 1'b1;
    int          m_off  = 0;
    bit          m_rdv  = 1'b0;
    logic [15:0] m_rreg = 16'h0;
    logic [1:0]  m_cee  = 2'b11;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b1;
            m_off  <= 0;
            m_rdv  <= 1'b0;
            m_rreg <= 16'h0;
            m_cee  <= 2'b11;
        end else if (m_busy) begin
            m_rdv <= 1'b0;
            m_cee <= 2'b11;
            // words at offset m_off of the lower and upper half are zeroed together
            m_mem[m_off]      <= 16'h0;
            m_mem[m_off + 64] <= 16'h0;
            if (clr) begin
                m_off <= 0;
            end else if (m_off == 63) begin
                m_off  <= 0;
                m_busy <= 1'b0;
            end else begin
                m_off <= m_off + 1;
            end
        end else begin
            m_rdv <= 1'b0;
            m_cee <= 2'b11;
            if (!ce_n) begin
                m_cee <= (adrs >= 7'd64) ? 2'b01 : 2'b10;
                if (!we_n) begin
                    m_mem[adrs] <= din;
                end else begin
                    m_rreg <= m_mem[adrs];
                    m_rdv  <= 1'b1;
                end
            end
            if (clr) begin
                m_busy <= 1'b1;
                m_off  <= 0;
            end
        end
    end

    // Per-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_rd_valid", 32'(rdv), 32'(m_rdv));
        chk("cyc_cee", 32'(cee), 32'(m_cee));
        chk("cyc_dataOut", 32'(dout), oe_n ? 32'h0 : 32'(m_rreg));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic acc(input bit wr, input logic [6:0] a, input logic [15:0] d);
        ce_n = 1'b0;
        we_n = ~wr;
        adrs = a;
        din  = d;
        step();
        ce_n = 1'b1;
        we_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, nf;
        bit rdv_seen;
        logic [6:0] rd_list [4];

        rst_n = 1'b0;
        adrs = '0; din = '0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b0; clr = 1'b0;
        f_adrs = '0; f_din = '0; f_ce_n = 1'b1; f_we_n = 1'b1; f_oe_n = 1'b0; f_clr = 1'b0;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_dataOut", 32'(dout), 32'h0);
        chk("rst_cee", 32'(cee), 32'h3);
        chk("rst_cee4", 32'(f_cee), 32'hF);
        rst_n = 1'b1;

        // Initial clear: both geometries sweep 64 offsets
        n = 0; nb = -1; nf = -1;
        while ((nb < 0 || nf < 0) && n < 200) begin
            step();
            n++;
            if (nb < 0 && !busy)   nb = n;
            if (nf < 0 && !f_busy) nf = n;
        end
        chk("clear_len", 32'(nb), 32'd64);
        chk("clear_len4", 32'(nf), 32'd64);

        // Boundary reads after clear, back-to-back
        rd_list[0] = 7'd0; rd_list[1] = 7'd63; rd_list[2] = 7'd64; rd_list[3] = 7'd127;
        for (int i = 0; i < 4; i++) begin
            acc(1'b0, rd_list[i], 16'h0);
            chk("clr_rd_valid", 32'(rdv), 32'h1);
            chk("clr_rd_data", 32'(dout), 32'h0);
        end

        // Writes and readback with bank enables
        acc(1'b1, 7'd5, 16'hA5A5);
        chk("wr5_cee", 32'(cee), 32'h2);
        chk("wr5_no_rdv", 32'(rdv), 32'h0);
        acc(1'b1, 7'd69, 16'h5A5A);
        chk("wr69_cee", 32'(cee), 32'h1);
        acc(1'b0, 7'd5, 16'h0);
        chk("rd5_data", 32'(dout), 32'hA5A5);
        chk("rd5_rdv", 32'(rdv), 32'h1);
        chk("rd5_cee", 32'(cee), 32'h2);
        acc(1'b0, 7'd69, 16'h0);
        chk("rd69_data", 32'(dout), 32'h5A5A);
        chk("rd69_cee", 32'(cee), 32'h1);

        // Write then read the next cycle, single pulse, output enable
        acc(1'b1, 7'd10, 16'h1234);
        acc(1'b0, 7'd10, 16'h0);
        chk("rd10_data", 32'(dout), 32'h1234);
        chk("rd10_rdv", 32'(rdv), 32'h1);
        step();
        chk("rd10_single_pulse", 32'(rdv), 32'h0);
        chk("rd10_cee_idle", 32'(cee), 32'h3);
        oe_n = 1'b1; #1;
        chk("oe_high_zero", 32'(dout), 32'h0);
        oe_n = 1'b0; #1;
        chk("oe_low_hold", 32'(dout), 32'h1234);

        // clr during a read: read completes with pre-clear data, then a full sweep
        clr = 1'b1;
        acc(1'b0, 7'd69, 16'h0);
        clr = 1'b0;
        chk("clr_rd_data", 32'(dout), 32'h5A5A);
        chk("clr_rd_rdv", 32'(rdv), 32'h1);
        chk("clr_busy", 32'(busy), 32'h1);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("clr_len", 32'(n), 32'd64);
        acc(1'b0, 7'd69, 16'h0);
        chk("post_clr_69", 32'(dout), 32'h0);
        acc(1'b0, 7'd10, 16'h0);
        chk("post_clr_10", 32'(dout), 32'h0);

        // Rewrite, start a clear, reset in the middle, ignored reads during the sweep
        acc(1'b1, 7'd100, 16'hCAFE);
        clr = 1'b1;
        step();
        clr = 1'b0;
        rdv_seen = 1'b0;
        ce_n = 1'b0; we_n = 1'b1; adrs = 7'd100;
        for (int i = 0; i < 20; i++) begin
            step();
            rdv_seen |= rdv;
        end
        rst_n = 1'b0; #1;
        chk("midrst_busy", 32'(busy), 32'h1);
        chk("midrst_cee", 32'(cee), 32'h3);
        step();
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
            rdv_seen |= rdv;
        end
        ce_n = 1'b1;
        chk("midrst_len", 32'(n), 32'd64);
        chk("midrst_no_rdv", 32'(rdv_seen), 32'h0);
        acc(1'b0, 7'd100, 16'h0);
        chk("midrst_rd100", 32'(dout), 32'h0);

        // Four-bank geometry (cleared alongside by the shared reset)
        n = 0;
        while (f_busy && n < 200) begin
            step();
            n++;
        end
        chk("b4_ready", 32'(f_busy), 32'h0);
        f_ce_n = 1'b0; f_we_n = 1'b0; f_adrs = 8'd200; f_din = 16'hBEEF;
        step();
        chk("b4_wr_cee", 32'(f_cee), 32'h7);
        chk("b4_wr_no_rdv", 32'(f_rdv), 32'h0);
        f_we_n = 1'b1;
        step();
        chk("b4_rd_data", 32'(f_dout), 32'hBEEF);
        chk("b4_rd_rdv", 32'(f_rdv), 32'h1);
        chk("b4_rd_cee", 32'(f_cee), 32'h7);
        f_adrs = 8'd72;
        step();
        chk("b4_rd72_data", 32'(f_dout), 32'h0);
        chk("b4_rd72_cee", 32'(f_cee), 32'hD);
        f_ce_n = 1'b1;
        step();
        chk("b4_idle_cee", 32'(f_cee), 32'hF);
        chk("b4_idle_rdv", 32'(f_rdv), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ram_banked_sync

// File: doc/ram_banked_sync.md
RAM_BANKED_SYNC -- requirements
Module: ram_banked_sync

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 7, SHALL set the address width; total depth is 2^ADDR_W words.
REQ-003 Parameter BANKS, default 2, SHALL set the bank count; it SHALL be a power of two, at least 2 and at most 2^(ADDR_W-1).
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 _rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 adrs  in  ADDR_W  SHALL be the word address, sampled at the rising edge of clk.
REQ-007 dataIn  in  DATA_W  SHALL be the write data.
REQ-008 _ce  in  1  SHALL be the active-low access strobe: one access per cycle when low.
REQ-009 _we  in  1  SHALL select the access type: low is write, high is read. It SHALL be ignored when _ce is high.
REQ-010 _oe  in  1  SHALL be the active-low output enable; it is combinational on dataOut only.
REQ-011 clr  in  1  SHALL be an active-high request to zero the whole array.
REQ-012 dataOut  out  DATA_W  SHALL carry the read data.
REQ-013 rd_valid  out  1  SHALL pulse high for one cycle when new read data is on the internal read register.
REQ-014 busy  out  1  SHALL be high while the clear sequence runs.
REQ-015 _cee  out  BANKS  SHALL carry the registered active-low per-bank enables of the last accepted access.

Function
REQ-016 Bank select SHALL be adrs[ADDR_W-1 -: log2(BANKS)]. The in-bank offset SHALL be the remaining low bits.
REQ-017 An accepted access SHALL drive exactly one _cee bit low, bit index = bank select. All _cee bits SHALL be high otherwise.
REQ-018 The FSM SHALL have two states, CLEAR and READY.
REQ-019 In CLEAR, a counter SHALL run from 0 to 2^ADDR_W/BANKS-1, one step per cycle. Each step SHALL write 0 at that offset in all banks at once.
REQ-020 CLEAR SHALL go to READY in the cycle after the last offset is written. busy SHALL fall on that same edge.
REQ-021 In CLEAR, _ce SHALL be ignored: no write occurs, no rd_valid pulses, and _cee stays all-high.
REQ-022 In READY, a write SHALL take effect at the clock edge that samples it. It SHALL produce no rd_valid pulse.
REQ-023 In READY, a read SHALL have a latency of 1 cycle: the read register loads and rd_valid is high in the cycle after the sampling edge.
REQ-024 The read register SHALL hold its value until the next read.
REQ-025 dataOut SHALL equal the read register when _oe is low, and all-zero when _oe is high.
REQ-026 Back-to-back reads on consecutive cycles SHALL each produce a rd_valid pulse, at full throughput.
REQ-027 A read of an address written in the previous cycle SHALL return the new data.
REQ-028 clr sampled high in READY SHALL enter CLEAR on the next edge.
REQ-029 An access sampled in the same cycle as clr SHALL still complete. A read in that cycle SHALL return pre-clear data with rd_valid.
REQ-030 clr sampled high while in CLEAR SHALL restart the counter at 0.
REQ-031 The address SHALL wrap by construction; every adrs value maps to a valid word.

Reset
REQ-032 On _rst low: state=CLEAR, counter=0, busy=1, rd_valid=0, read register=0, _cee=all-ones. dataOut SHALL be 0.
REQ-033 Reset asserted mid-clear or mid-read SHALL abandon the operation and restart the full clear sequence after _rst releases.
REQ-034 Array contents SHALL NOT depend on reset; they SHALL be defined only by the clear sequence.

Structure
REQ-035 Package ram_pkg SHALL hold the FSM state typedef (CLEAR, READY) and the default values of DATA_W, ADDR_W and BANKS.
REQ-036 Each bank SHALL be one instance of sub-module ram_bank: a single-port synchronous array with a registered read, of depth 2^ADDR_W/BANKS, generated BANKS times.
REQ-037 The read mux SHALL select from the bank-select value registered with the access.

Verification
REQ-038 Release reset with defaults -> busy high for exactly 64 cycles, then low; reads of addresses 0, 63, 64 and 127 each return 0x0000.
REQ-039 Write 0xA5A5 to address 5 and 0x5A5A to address 69, then read both with _oe low -> 0xA5A5 and 0x5A5A, each one cycle later with rd_valid. During the accesses, _cee = 2'b10 for address 5 and 2'b01 for address 69.
REQ-040 Write 0x1234 to address 10, then read address 10 on the next cycle -> 0x1234 with a single rd_valid pulse; with _oe high, dataOut = 0x0000 while the register holds 0x1234.
REQ-041 Pulse clr while reading address 69 (holding 0x5A5A) -> rd_valid with 0x5A5A, then busy for 64 cycles, then address 69 reads 0x0000.
REQ-042 Assert _rst for one cycle in the middle of the clear sequence -> clear restarts, busy stays high for 64 cycles after release, and no rd_valid occurs.
REQ-043 Rerun with BANKS=4, ADDR_W=8 -> a clear of 64 cycles; address 200 selects bank 3 (_cee = 4'b0111); write/readback of 0xBEEF succeeds.
